// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud constants and the
// bpssel -> bit-period mapping used by both receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_38400  = 38400;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;
  localparam int unsigned BAUD_230400 = 230400;
  localparam int unsigned BAUD_460800 = 460800;
  localparam int unsigned BAUD_921600 = 921600;

  // Rounded divide kept inside each arm so every branch folds to a constant.
  function automatic logic [15:0] bit_period(input int unsigned clk_freq,
                                             input logic [2:0]  sel);
    logic [15:0] d;
    case (sel)
      3'd0:    d = 16'((clk_freq + BAUD_9600   / 2) / BAUD_9600);
      3'd1:    d = 16'((clk_freq + BAUD_19200  / 2) / BAUD_19200);
      3'd2:    d = 16'((clk_freq + BAUD_38400  / 2) / BAUD_38400);
      3'd3:    d = 16'((clk_freq + BAUD_57600  / 2) / BAUD_57600);
      3'd4:    d = 16'((clk_freq + BAUD_115200 / 2) / BAUD_115200);
      3'd5:    d = 16'((clk_freq + BAUD_230400 / 2) / BAUD_230400);
      3'd6:    d = 16'((clk_freq + BAUD_460800 / 2) / BAUD_460800);
      default: d = 16'((clk_freq + BAUD_921600 / 2) / BAUD_921600);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_baud.sv
// Baud timer: latches bpssel on start, ticks at the half period and then
// every full bit period while enabled.
module uart_rx_baud #(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       en,
  input  logic [2:0] bpssel,
  output logic       tick
);
  import uart_pkg::*;

  logic [15:0] period_q;
  logic [15:0] cnt_q;
  logic        half_q;
  logic [15:0] target;

  assign target = half_q ? {1'b0, period_q[15:1]} : period_q;
  assign tick   = en && !start && (cnt_q == target - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      cnt_q    <= '0;
      half_q   <= 1'b1;
    end else if (start) begin
      period_q <= bit_period(CLK_FREQ, bpssel);
      cnt_q    <= '0;
      half_q   <= 1'b1;
    end else if (en) begin
      if (tick) begin
        cnt_q  <= '0;
        half_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_bps.sv
// UART receiver, 8N1 with selectable baud rate. Define UART_RX_PARITY_EN for
// 8E1 frames with par_err reporting.
module uart_rx_bps #(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] bpssel,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_int,
  output logic       frame_err,
  output logic       par_err,
  output logic       busy
);
  import uart_pkg::*;

  rx_state_e   state_q, state_d;
  logic [2:0]  sync_q;
  logic        line, fall;
  logic        tick, start, en;
  logic        sample, done_ok, done_err;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;

  assign line = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign busy = (state_q != ST_IDLE);
  assign en   = (state_q == ST_START) || (state_q == ST_DATA) ||
                (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_rx_baud #(.CLK_FREQ(CLK_FREQ)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .en     (en),
    .bpssel (bpssel),
    .tick   (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_sample;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sync_q  <= '1;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], rs232_rx};
    end
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    sample   = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (fall) begin
        start   = 1'b1;
        state_d = ST_START;
      end
      ST_START: if (tick) state_d = line ? ST_IDLE : ST_DATA;
      ST_DATA: if (tick) begin
        sample = 1'b1;
        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (tick) begin
        par_sample = 1'b1;
        state_d    = ST_STOP;
      end
`endif
      ST_STOP: if (tick) begin
        if (line) begin
          done_ok = 1'b1;
          state_d = ST_IDLE;
        end else begin
          done_err = 1'b1;
          state_d  = ST_BREAK;
        end
      end
      ST_BREAK: if (line) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx_q <= '0;
      shreg_q   <= '0;
      rx_data   <= '0;
      rx_int    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_int    <= done_ok;
      frame_err <= done_err;
      if (sample) begin
        bit_idx_q <= bit_idx_q + 3'd1;
        shreg_q   <= {line, shreg_q[7:1]};
      end
      if (done_ok) rx_data <= shreg_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (par_sample) par_bit_q <= line;
      par_err_q <= done_ok & ((^shreg_q) ^ par_bit_q);
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_bps.sv
// Scoreboard bench for uart_rx_bps: expected bytes queued at send time,
// popped and compared on each rx_int.
module tb_uart_rx_bps;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] bpssel;
  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       rx_int, frame_err, par_err, busy;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   int_cnt = 0;
  int   fe_cnt = 0;
  int   last_int_cyc = 0;
  int   t_drop = 0;
  logic [7:0] last_good = 8'h00;
  int   d_tab[8] = '{5208, 2604, 1302, 868, 434, 217, 109, 54};

  uart_rx_bps #(.CLK_FREQ(50000000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bpssel    (bpssel),
    .rs232_rx  (rs232_rx),
    .rx_data   (rx_data),
    .rx_int    (rx_int),
    .frame_err (frame_err),
    .par_err   (par_err),
    .busy      (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) fe_cnt++;
      if (rx_int || frame_err) begin
        vectors++;
        if (rx_int && frame_err) begin
          miscompares++;
          $display("FAIL strobe_overlap rx_int=%b frame_err=%b required not both", rx_int, frame_err);
        end
      end
      if (rx_int) begin
        exp_t e;
        int_cnt++;
        last_int_cyc = cyc;
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rx_int rx_data=%h required no strobe", rx_data);
        end else begin
          e = sb_q.pop_front();
          if (rx_data !== e.data) begin
            miscompares++;
            $display("FAIL rx_data got %h required %h", rx_data, e.data);
          end
          vectors++;
          if (par_err !== e.par) begin
            miscompares++;
            $display("FAIL par_err got %b required %b", par_err, e.par);
          end
        end
      end else if (par_err) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_par_err got 1 required 0");
      end
    end
  end

  // Called on a negedge; the line stays at the stop value on return.
  task automatic send_frame(input logic [7:0] data, input logic [2:0] sel,
                            input logic [2:0] mid_sel, input logic stop_bit,
                            input logic par_bit);
    int d;
    d = d_tab[sel];
    bpssel   = sel;
    rs232_rx = 1'b0;
    t_drop   = cyc;
    repeat (d) @(negedge clk);
    bpssel = mid_sel;
    for (int i = 0; i < 8; i++) begin
      rs232_rx = data[i];
      repeat (d) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rs232_rx = par_bit;
    repeat (d) @(negedge clk);
`else
    if (par_bit === 1'bx) rs232_rx = 1'b1;
`endif
    rs232_rx = stop_bit;
    repeat (d) @(negedge clk);
  endtask

  task automatic push_good(input logic [7:0] data);
    sb_q.push_back('{data: data, par: 1'b0});
    last_good = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rs232_rx = 1'b1; bpssel = 3'd0;
    repeat (3) @(negedge clk);
    vectors += 5;
    if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got %h required 00", rx_data); end
    if (rx_int !== 1'b0) begin miscompares++; $display("FAIL reset_rx_int got %b required 0", rx_int); end
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got %b required 0", frame_err); end
    if (par_err !== 1'b0) begin miscompares++; $display("FAIL reset_par_err got %b required 0", par_err); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b required 0", busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_byte();
    int n0, dt;
    logic [7:0] b;
    n0 = int_cnt;
    b = 8'h55;
    push_good(b);
    send_frame(b, 3'd4, 3'd4, 1'b1, ^b);
    dt = last_int_cyc - t_drop;
    vectors += 3;
    if (int_cnt !== n0 + 1) begin miscompares++; $display("FAIL good_int_count got %0d required %0d", int_cnt - n0, 1); end
    if (dt < 4125 || dt > 4127) begin miscompares++; $display("FAIL good_latency got %0d required 4126+-1", dt); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL good_busy_after got %b required 0", busy); end
    // bpssel altered mid-frame must not disturb the latched rate
    b = 8'hC6;
    push_good(b);
    send_frame(b, 3'd4, 3'd0, 1'b1, ^b);
    vectors++;
    if (int_cnt !== n0 + 2) begin miscompares++; $display("FAIL latch_int_count got %0d required %0d", int_cnt - n0, 2); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_glitch();
    int n0, f0, busy_cycles;
    n0 = int_cnt; f0 = fe_cnt; busy_cycles = 0;
    bpssel = 3'd0;
    rs232_rx = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    rs232_rx = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    vectors += 4;
    if (int_cnt !== n0) begin miscompares++; $display("FAIL glitch_rx_int got %0d required 0", int_cnt - n0); end
    if (fe_cnt !== f0) begin miscompares++; $display("FAIL glitch_frame_err got %0d required 0", fe_cnt - f0); end
    if (busy_cycles < 2500 || busy_cycles >= 2700) begin miscompares++; $display("FAIL glitch_busy_len got %0d required 2500..2699", busy_cycles); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_end got %b required 0", busy); end
  endtask

  task automatic test_frame_err();
    int n0, f0;
    logic [7:0] b;
    n0 = int_cnt; f0 = fe_cnt;
    b = 8'hA3;
    send_frame(b, 3'd4, 3'd4, 1'b0, ^b);
    repeat (3 * 434) @(negedge clk);
    vectors += 4;
    if (fe_cnt !== f0 + 1) begin miscompares++; $display("FAIL ferr_count got %0d required 1", fe_cnt - f0); end
    if (int_cnt !== n0) begin miscompares++; $display("FAIL ferr_rx_int got %0d required 0", int_cnt - n0); end
    if (rx_data !== last_good) begin miscompares++; $display("FAIL ferr_rx_data got %h required %h", rx_data, last_good); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL ferr_busy_break got %b required 1", busy); end
    rs232_rx = 1'b1;
    repeat (10) @(negedge clk);
    vectors += 2;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL ferr_busy_idle got %b required 0", busy); end
    if (fe_cnt !== f0 + 1) begin miscompares++; $display("FAIL ferr_single got %0d required 1", fe_cnt - f0); end
    b = 8'h5A;
    push_good(b);
    send_frame(b, 3'd4, 3'd4, 1'b1, ^b);
    vectors++;
    if (int_cnt !== n0 + 1) begin miscompares++; $display("FAIL ferr_recover got %0d required 1", int_cnt - n0); end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [7:0] a, b;
    n0 = int_cnt;
    a = 8'h00; b = 8'hFF;
    push_good(a);
    push_good(b);
    send_frame(a, 3'd7, 3'd7, 1'b1, ^a);
    send_frame(b, 3'd7, 3'd7, 1'b1, ^b);
    repeat (10) @(negedge clk);
    vectors += 2;
    if (int_cnt !== n0 + 2) begin miscompares++; $display("FAIL b2b_count got %0d required 2", int_cnt - n0); end
    if (rx_data !== 8'hFF) begin miscompares++; $display("FAIL b2b_last got %h required ff", rx_data); end
  endtask

  task automatic test_reset_mid();
    int n0;
    logic [7:0] b;
    b = 8'h99;
    bpssel = 3'd4;
    rs232_rx = 1'b0;
    repeat (434) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rs232_rx = b[i];
      repeat (434) @(negedge clk);
    end
    rs232_rx = b[4];
    repeat (200) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    vectors += 5;
    if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rmid_rx_data got %h required 00", rx_data); end
    if (rx_int !== 1'b0) begin miscompares++; $display("FAIL rmid_rx_int got %b required 0", rx_int); end
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rmid_frame_err got %b required 0", frame_err); end
    if (par_err !== 1'b0) begin miscompares++; $display("FAIL rmid_par_err got %b required 0", par_err); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b required 0", busy); end
    rs232_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n0 = int_cnt;
    b = 8'h3C;
    push_good(b);
    send_frame(b, 3'd4, 3'd4, 1'b1, ^b);
    vectors += 2;
    if (int_cnt !== n0 + 1) begin miscompares++; $display("FAIL rmid_recover got %0d required 1", int_cnt - n0); end
    if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL rmid_data got %h required 3c", rx_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int n0;
    n0 = int_cnt;
    sb_q.push_back('{data: 8'h01, par: 1'b1});
    send_frame(8'h01, 3'd5, 3'd5, 1'b1, 1'b0);
    sb_q.push_back('{data: 8'h01, par: 1'b0});
    send_frame(8'h01, 3'd5, 3'd5, 1'b1, 1'b1);
    vectors++;
    if (int_cnt !== n0 + 2) begin miscompares++; $display("FAIL parity_count got %0d required 2", int_cnt - n0); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_byte();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    repeat (10) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_bps.md
# uart_rx_bps

Asynchronous serial receiver with selectable baud rate: the receive-side counterpart of the board's UART transmit path. It recovers 8-bit frames from the RS232 RX pin, samples each bit at its midpoint, and delivers each byte with a one-cycle strobe to the CPLD control logic. It shares the same 3-bit baud select encoding and 50 MHz system clock as the transmit path.

## Interface
- CLK_FREQ, 50000000: system clock frequency in Hz; all divisors derive from it.
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- bpssel  input  3  baud select:
  - 0: 9600
  - 1: 19200
  - 2: 38400
  - 3: 57600
  - 4: 115200
  - 5: 230400
  - 6: 460800
  - 7: 921600
- rs232_rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  last good byte received.
- rx_int  output  1  one-cycle pulse when rx_data is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- par_err  output  1  one-cycle pulse on parity mismatch; constant 0 without the parity feature.
- busy  output  1  high from start-edge detection until return to IDLE.

## Operation
- **Input conditioning.** rs232_rx passes through a 2-flop synchronizer plus a third flop for falling-edge detect. All three flops reset to 1.
- **Bit period.** D = round(CLK_FREQ/baud): 5208, 2604, 1302, 868, 434, 217, 109, 54 for bpssel 0..7. H = floor(D/2).
- **Baud latch.** bpssel is latched on start-edge detection. Changes mid-frame have no effect until the next frame.
- **States:**
  - IDLE → START on a synchronized falling edge.
  - START: at count H, if the line is low → DATA; if high → IDLE (glitch rejected, no outputs pulse).
  - DATA: 8 samples, one every D cycles, LSB first, shifted into a shift register. After bit 7 → PARITY (macro) or STOP.
  - PARITY (macro only): one sample at D.
  - STOP: sample at D.
    - Line high: load rx_data from the shift register, pulse rx_int, pulse par_err if the parity check failed, then → IDLE.
    - Line low: pulse frame_err, leave rx_data unchanged, no rx_int, then → BREAK.
  - BREAK: wait for the synchronized line to be high, then → IDLE. A held-low line (break condition) yields exactly one frame_err.
- **Counters.** The bit counter is 16 bits wide and clears on every sample point. The bit index is 3 bits and wraps 7→0 on leaving DATA.
- **Back-to-back frames.** A new start edge is accepted in the first IDLE cycle after STOP.
- **Reset.** Reset mid-frame aborts immediately. After reset: IDLE, rx_data = 0x00, rx_int = 0, frame_err = 0, par_err = 0, busy = 0.

## Timing
- **T0 reference.** T0 is the cycle in which the edge detect fires, 2–3 clk after the pin edge because of synchronizer delay.
- **Sample points.** Start check at T0+H. Data bit k at T0+H+(k+1)·D. Parity at T0+H+9D. Stop at T0+H+9D, or T0+H+10D with parity.
- **Result.** rx_data, rx_int and frame_err are registered and become visible in the cycle after the stop sample.
- **Strobes.** rx_int, frame_err and par_err are each exactly one clk wide. rx_int and frame_err are never high together.
- **Tolerance.** Receiver clock tolerance is ±2% at all rates.

## Configuration
- UART_RX_PARITY_EN defined: the frame carries an even-parity bit between data and stop. par_err pulses with rx_int when the XOR of the 8 data bits and the parity bit is 1. rx_data is still updated.
- Undefined: 8N1 frames, no PARITY state, par_err tied 0.

## Structure
- **Package uart_pkg:**
  - function mapping bpssel to D for a given CLK_FREQ
  - state encoding localparams: IDLE, START, DATA, PARITY, STOP, BREAK
  - baud-rate constants
- **Sub-module uart_rx_baud:** latches bpssel on a start strobe and runs the bit counter. It emits a sample tick at H and then every D cycles while enabled. It is reusable by the transmit path.

## Test plan
- **Good byte.** bpssel=4, send 0x55 in 8N1 → rx_data=0x55, one rx_int pulse at T0+217+9·434+1 (±1), busy low afterwards.
- **Glitch rejection.** rs232_rx low for 100 clk at bpssel=0 → no rx_int, no frame_err, busy high for fewer than 2700 clk, then back to IDLE.
- **Framing error.** Send 0xA3 with the stop bit driven 0, then hold the line low for 3D → exactly one frame_err pulse, rx_data unchanged, no rx_int until the line goes high and a new frame arrives.
- **Back-to-back.** bpssel=7, send 0x00 then 0xFF with no idle gap → two rx_int pulses, rx_data=0x00 then 0xFF.
- **Reset mid-frame.** Assert rst_n low during data bit 4 → all outputs at reset values within the same cycle, state IDLE. The next full frame 0x3C is received correctly.
- **Parity (UART_RX_PARITY_EN).** Send 0x01 with parity bit 0 → rx_data=0x01, rx_int and par_err pulse together. Send 0x01 with parity bit 1 → par_err stays 0.
